cfg_sequencer: RTL and testbench

CFG_SEQUENCER -- requirements
Module: cfg_sequencer

---
 rtl/cfg_seq_pkg.sv | 18 +
 rtl/cfg_seq_beat_counter.sv | 29 ++
 rtl/cfg_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cfg_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_seq_pkg.sv
// Shared types and constants for the LUT-tile configuration sequencer.
// Optional tlast checking is enabled by defining CFG_SEQ_TLAST_CHECK_EN.
package cfg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_STREAM,
        ST_WAIT_LOAD,
        ST_NEXT,
        ST_RUN,
        ST_DRAIN,
        ST_ERROR
    } cfg_seq_state_t;

    localparam int unsigned CFG_SEQ_TIMEOUT_DEF = 255;

endpackage

// File: rtl/cfg_seq_beat_counter.sv
// Saturating up-counter with clear, increment and terminal-count flags.
// Shared by the beat counter and the load-timeout counter.
module cfg_seq_beat_counter #(
    parameter int unsigned MAX = 4,
    parameter int unsigned CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last,
    output logic o_tc
);

    logic [CW-1:0] r_cnt;

    // Saturates at MAX so a stray increment can never wrap to zero.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_tc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc   = (r_cnt == CW'(MAX));
    assign o_last = (r_cnt == CW'(MAX - 1));

endmodule

// File: rtl/cfg_sequencer.sv
// Loads truth tables into NUM_TILES LUT tiles in turn, then enables run.
// Define CFG_SEQ_TLAST_CHECK_EN to validate s_tlast against the beat count.
module cfg_sequencer
    import cfg_seq_pkg::*;
#(
    parameter int unsigned NUM_TILES = 4,
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned TIMEOUT   = CFG_SEQ_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tdata,
    input  logic                 s_tlast,
    output logic [NUM_TILES-1:0] tile_cfg,
    output logic [NUM_TILES-1:0] tile_tvalid,
    output logic                 tile_tdata,
    output logic                 tile_tlast,
    input  logic [NUM_TILES-1:0] tile_tready,
    input  logic [NUM_TILES-1:0] tile_cfg_ready,
    output logic                 run,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam int unsigned DEPTH = 2 ** WIDTH;
    localparam int unsigned SW    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam logic [SW-1:0] LAST_SEL = SW'(NUM_TILES - 1);

    cfg_seq_state_t r_state;
    cfg_seq_state_t w_next;
    logic [SW-1:0]  r_sel;
    logic           r_done;
    logic           w_stream;
    logic           w_hs;
    logic           w_beat_last;
    logic           w_beat_tc;
    logic           w_to_last;
    logic           w_to_tc;
    logic           w_tlast_bad;
    logic           w_sel_clr;
    logic           w_sel_inc;
    logic           w_go;
    logic [NUM_TILES-1:0] w_sel_oh;

    cfg_seq_beat_counter #(.MAX(DEPTH)) u_beat (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_state == ST_SELECT),
        .i_inc  (w_hs),
        .o_last (w_beat_last),
        .o_tc   (w_beat_tc)
    );

    cfg_seq_beat_counter #(.MAX(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_state != ST_WAIT_LOAD),
        .i_inc  (1'b1),
        .o_last (w_to_last),
        .o_tc   (w_to_tc)
    );

    assign w_sel_oh    = NUM_TILES'(1) << r_sel;
    assign w_stream    = (r_state == ST_STREAM) && !w_beat_tc;
    assign s_tready    = w_stream && tile_tready[r_sel];
    assign w_hs        = s_tvalid && s_tready;
    assign tile_tvalid = {NUM_TILES{w_stream && s_tvalid}} & w_sel_oh;
    assign tile_cfg    = {NUM_TILES{r_state == ST_SELECT}} & w_sel_oh;
    assign tile_tdata  = s_tdata;

`ifdef CFG_SEQ_TLAST_CHECK_EN
    // Only the very last beat of the last tile may carry tlast.
    assign w_tlast_bad = w_hs &&
        (s_tlast != ((r_sel == LAST_SEL) && w_beat_last));
    assign tile_tlast  = s_tlast;
`else
    logic w_unused_tlast;
    assign w_unused_tlast = s_tlast;
    assign w_tlast_bad    = 1'b0;
    assign tile_tlast     = (r_state == ST_STREAM) && w_beat_last;
`endif

    always_comb begin
        w_next    = r_state;
        w_sel_clr = 1'b0;
        w_sel_inc = 1'b0;
        w_go      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next    = ST_SELECT;
                    w_sel_clr = 1'b1;
                    w_go      = 1'b1;
                end
            end
            ST_SELECT: w_next = ST_STREAM;
            ST_STREAM: begin
                if (w_tlast_bad) begin
                    w_next = ST_ERROR;
                end else if (w_hs && w_beat_last) begin
                    w_next = ST_WAIT_LOAD;
                end
            end
            ST_WAIT_LOAD: begin
                if (tile_cfg_ready[r_sel]) begin
                    w_next = ST_NEXT;
                end else if (w_to_last || w_to_tc) begin
                    w_next = ST_ERROR;
                end
            end
            ST_NEXT: begin
                if (r_sel == LAST_SEL) begin
                    w_next = ST_RUN;
                end else begin
                    w_next    = ST_SELECT;
                    w_sel_inc = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_next = ST_IDLE;
                end else if (start) begin
                    w_next = ST_DRAIN;
                    w_go   = 1'b1;
                end
            end
            ST_DRAIN: begin
                w_next    = ST_SELECT;
                w_sel_clr = 1'b1;
            end
            ST_ERROR: begin
                if (start) begin
                    w_next    = ST_SELECT;
                    w_sel_clr = 1'b1;
                    w_go      = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_sel_clr) begin
                r_sel <= '0;
            end else if (w_sel_inc) begin
                r_sel <= r_sel + SW'(1);
            end
            if (w_go) begin
                r_done <= 1'b0;
            end else if (r_state == ST_NEXT && r_sel == LAST_SEL) begin
                r_done <= 1'b1;
            end
        end
    end

    assign run   = (r_state == ST_RUN);
    assign error = (r_state == ST_ERROR);
    assign done  = r_done;
    assign busy  = (r_state == ST_SELECT) || (r_state == ST_STREAM) ||
                   (r_state == ST_WAIT_LOAD) || (r_state == ST_NEXT) ||
                   (r_state == ST_DRAIN);

endmodule

// File: tb/tb_cfg_sequencer.sv
// Directed/randomised bench for cfg_sequencer with a tile-level reference model.
// Works with and without CFG_SEQ_TLAST_CHECK_EN.
module tb_cfg_sequencer;

    localparam int NT     = 4;
    localparam int W      = 2;
    localparam int D      = 4;
    localparam int TO     = 10;
    localparam int BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tdata = 1'b0;
    logic          s_tlast = 1'b0;
    logic [NT-1:0] tile_cfg;
    logic [NT-1:0] tile_tvalid;
    logic          tile_tdata;
    logic          tile_tlast;
    logic [NT-1:0] tile_tready = '1;
    logic [NT-1:0] tile_cfg_ready = '0;
    logic          run;
    logic          busy;
    logic          done;
    logic          error;

    cfg_sequencer #(
        .NUM_TILES (NT),
        .WIDTH     (W),
        .TIMEOUT   (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .stop           (stop),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tdata        (s_tdata),
        .s_tlast        (s_tlast),
        .tile_cfg       (tile_cfg),
        .tile_tvalid    (tile_tvalid),
        .tile_tdata     (tile_tdata),
        .tile_tlast     (tile_tlast),
        .tile_tready    (tile_tready),
        .tile_cfg_ready (tile_cfg_ready),
        .run            (run),
        .busy           (busy),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NT*D-1:0] src_v;
    logic [D-1:0]    rx_v [NT];
    int              rx_n [NT];
    int              pulse_v [8];
    int              pulse_n;
    int              pulse_k0;
    int              hs_k;
    int              err_k;
    logic            got_run;
    logic            got_err;
    logic            first_run;
    logic            first_busy;
    logic            first_err;
    logic [NT-1:0]   first_cfg;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_tready"}, 32'(s_tready), 0);
        chk({tag, "_tile_cfg"}, 32'(tile_cfg), 0);
        chk({tag, "_tile_tvalid"}, 32'(tile_tvalid), 0);
        chk({tag, "_run"}, 32'(run), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_tlast"}, 32'(tile_tlast), 0);
    endtask

    // One configuration pass: a random bitstream is offered, tiles take beats
    // and report loaded after a random delay; stops on run, error or abort.
    task automatic do_config(input int no_rdy, input int stall_t,
                             input int abort_t, input int bad_pos,
                             input int bs_t);
        int pos;
        int cur;
        bit streaming;
        int st_left;
        bit st_done;
        bit bs_done;
        bit fin;
        int dly [NT];
        logic [NT-1:0] e_tv;
        pos = 0;
        cur = 0;
        streaming = 0;
        st_left = 0;
        st_done = 0;
        bs_done = 0;
        fin = 0;
        for (int i = 0; i < NT*D; i++) src_v[i] = 1'($urandom_range(0, 1));
        for (int t = 0; t < NT; t++) begin
            rx_v[t] = '0;
            rx_n[t] = 0;
            dly[t]  = $urandom_range(0, 3);
        end
        pulse_n = 0;
        pulse_k0 = -1;
        hs_k = -1;
        err_k = -1;
        got_run = 0;
        got_err = 0;
        tile_cfg_ready = '0;
        tile_tready = '1;
        s_tvalid = 0;
        stop = 0;
        start = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < BUDGET && !fin; k++) begin
            start = 1'b0;
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata = (pos < NT*D) ? src_v[pos] : 1'b0;
`ifdef CFG_SEQ_TLAST_CHECK_EN
            s_tlast = (bad_pos >= 0) ? (pos == bad_pos) : (pos == NT*D-1);
`else
            s_tlast = 1'($urandom_range(0, 1));
`endif
            for (int t = 0; t < NT; t++)
                tile_tready[t] = ($urandom_range(0, 4) != 0);
            if (streaming && cur == stall_t && rx_n[cur] == 2 && !st_done) begin
                st_left = 5;
                st_done = 1;
            end
            if (st_left > 0) begin
                tile_tready[stall_t] = 1'b0;
                st_left--;
            end
            if (streaming && cur == bs_t && rx_n[cur] == 1 && !bs_done) begin
                start = 1'b1;
                bs_done = 1;
            end
            for (int t = 0; t < NT; t++) begin
                if (rx_n[t] == D && dly[t] > 0) dly[t]--;
                tile_cfg_ready[t] = (rx_n[t] == D && dly[t] == 0 && t != no_rdy);
            end
            @(negedge clk);
            if (k == 0) begin
                first_run  = run;
                first_busy = busy;
                first_err  = error;
                first_cfg  = tile_cfg;
            end
            if (error) begin
                got_err = 1;
                err_k = k;
                fin = 1;
                chk("err_run", 32'(run), 0);
                chk("err_s_tready", 32'(s_tready), 0);
                chk("err_busy", 32'(busy), 0);
            end else if (run) begin
                got_run = 1;
                fin = 1;
                chk("run_busy", 32'(busy), 0);
                chk("run_done", 32'(done), 1);
                chk("run_s_tready", 32'(s_tready), 0);
            end else begin
                chk("busy", 32'(busy), 1);
                chk("done_cleared", 32'(done), 0);
                e_tv = '0;
                if (streaming) e_tv[cur] = s_tvalid;
                chk("s_tready", 32'(s_tready),
                    32'(streaming ? tile_tready[cur] : 1'b0));
                chk("tile_tvalid", 32'(tile_tvalid), 32'(e_tv));
                chk("tile_tdata", 32'(tile_tdata), 32'(s_tdata));
                if (streaming && s_tvalid && s_tready) begin
`ifdef CFG_SEQ_TLAST_CHECK_EN
                    chk("tile_tlast", 32'(tile_tlast), 32'(s_tlast));
`else
                    chk("tile_tlast", 32'(tile_tlast), 32'(rx_n[cur] == D-1));
`endif
                    if (rx_n[cur] < D) rx_v[cur][rx_n[cur]] = s_tdata;
                    rx_n[cur]++;
                    pos++;
                    hs_k = k;
                    if (rx_n[cur] == D) streaming = 0;
                    if (cur == abort_t && rx_n[cur] == 2) fin = 1;
                end
                if (tile_cfg != '0) begin
                    if (pulse_n == 0) pulse_k0 = k;
                    if (pulse_n < 8) pulse_v[pulse_n] = int'(tile_cfg);
                    pulse_n++;
                    for (int t = 0; t < NT; t++) if (tile_cfg[t]) cur = t;
                    streaming = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 0;
        start = 0;
        chk("cycle_budget", 32'(fin), 1);
    endtask

    task automatic check_cfg(input string tag);
        chk({tag, "_got_run"}, 32'(got_run), 1);
        chk({tag, "_pulse_count"}, pulse_n, NT);
        for (int t = 0; t < NT && t < pulse_n; t++)
            chk({tag, "_pulse_order"}, pulse_v[t], 1 << t);
        for (int t = 0; t < NT; t++) begin
            chk({tag, "_beats"}, rx_n[t], D);
            chk({tag, "_bits"}, 32'(rx_v[t]), 32'(src_v[t*D +: D]));
        end
    endtask

    initial begin
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk_all_zero("idle");
        @(posedge clk);
        #1;

        // Full load with a 5-cycle stall on tile 1.
        do_config(-1, 1, -1, -1, -1);
        check_cfg("basic");
        chk("basic_first_pulse", pulse_k0, 0);

        // stop leaves RUN; done stays set.
        stop = 1;
        @(negedge clk);
        chk("stop_run_still", 32'(run), 1);
        @(posedge clk);
        #1;
        stop = 0;
        @(negedge clk);
        chk("stop_run", 32'(run), 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_done", 32'(done), 1);
        @(posedge clk);
        #1;

        // start while busy must be ignored.
        do_config(-1, -1, -1, -1, 2);
        check_cfg("busy_start");

        // start in RUN: one DRAIN cycle then reload from tile 0.
        do_config(-1, 3, -1, -1, -1);
        chk("drain_run", 32'(first_run), 0);
        chk("drain_busy", 32'(first_busy), 1);
        chk("drain_cfg", 32'(first_cfg), 0);
        chk("drain_first_pulse", pulse_k0, 1);
        check_cfg("drain");

        // start and stop together in RUN: stop wins.
        start = 1;
        stop = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        start = 0;
        stop = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("startstop_run", 32'(run), 0);
            chk("startstop_busy", 32'(busy), 0);
            chk("startstop_cfg", 32'(tile_cfg), 0);
            @(posedge clk);
            #1;
        end

        // Tile 2 never reports loaded: timeout.
        do_config(2, -1, -1, -1, -1);
        chk("to_got_err", 32'(got_err), 1);
        chk("to_latency", err_k - hs_k, TO + 1);
        chk("to_pulses", pulse_n, 3);
        chk("to_beats", rx_n[2], D);

        s_tvalid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_sticky", 32'(error), 1);
            chk("err_no_ready", 32'(s_tready), 0);
            chk("err_no_run", 32'(run), 0);
            @(posedge clk);
            #1;
        end
        s_tvalid = 0;

        // start in ERROR clears error and reloads.
        do_config(-1, -1, -1, -1, -1);
        chk("err_restart_clear", 32'(first_err), 0);
        check_cfg("err_restart");

`ifdef CFG_SEQ_TLAST_CHECK_EN
        do_config(-1, -1, -1, 4, -1);
        chk("tlast_got_err", 32'(got_err), 1);
        chk("tlast_latency", err_k - hs_k, 1);
        chk("tlast_beats_t1", rx_n[1], 1);
        do_config(-1, -1, -1, -1, -1);
        check_cfg("tlast_recover");
`endif

        // Reset while tile 1 is mid-stream.
        do_config(-1, -1, 1, -1, -1);
        rst_n = 0;
        s_tvalid = 1;
        s_tdata = 0;
        s_tlast = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_all_zero("midrst");
            @(posedge clk);
            #1;
        end
        s_tvalid = 0;
        do_config(-1, -1, -1, -1, -1);
        chk("rst_reload_first_pulse", pulse_k0, 0);
        check_cfg("rst_reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
